// File: rtl/anti_theft_pkg.sv
// rtl/anti_theft_pkg.sv - shared interval codes, default delays and timer state type
package anti_theft_pkg;

    localparam logic [1:0] INT_ARM    = 2'd0;
    localparam logic [1:0] INT_DRIVER = 2'd1;
    localparam logic [1:0] INT_PASS   = 2'd2;
    localparam logic [1:0] INT_ALARM  = 2'd3;

    localparam logic [3:0] DEF_T_ARM    = 4'd6;
    localparam logic [3:0] DEF_T_DRIVER = 4'd8;
    localparam logic [3:0] DEF_T_PASS   = 4'd15;
    localparam logic [3:0] DEF_T_ALARM  = 4'd10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } timer_state_t;

endpackage

// File: rtl/anti_theft_interval_timer_prescaler.sv
// rtl/anti_theft_interval_timer_prescaler.sv - one-second tick divider with clear and enable
module one_sec_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_presc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc <= '0;
        end else if (i_clear) begin
            r_presc <= '0;
        end else if (i_enable) begin
            r_presc <= (r_presc == LAST) ? '0 : r_presc + 1'b1;
        end
    end

    // A clear in the same cycle wins, so a restart never sees a stale tick.
    assign o_tick = i_enable && !i_clear && (r_presc == LAST);

endmodule

// File: rtl/anti_theft_interval_timer.sv
// rtl/anti_theft_interval_timer.sv - programmable-slot countdown timer with one-cycle expiry pulse
module anti_theft_interval_timer
    import anti_theft_pkg::*;
#(
    parameter int         TICK_DIV         = 50_000_000,
    parameter logic [3:0] T_ARM_DEFAULT    = DEF_T_ARM,
    parameter logic [3:0] T_DRIVER_DEFAULT = DEF_T_DRIVER,
    parameter logic [3:0] T_PASS_DEFAULT   = DEF_T_PASS,
    parameter logic [3:0] T_ALARM_DEFAULT  = DEF_T_ALARM
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_interval,
    input  logic       i_start_timer,
    input  logic [1:0] i_prog_sel,
    input  logic [3:0] i_prog_value,
    input  logic       i_reprogram,
    output logic       o_expired,
    output logic       o_busy,
    output logic [3:0] o_seconds_left
);

    timer_state_t r_state;
    timer_state_t w_state_next;
    logic [3:0]   r_slot [4];
    logic [3:0]   r_remaining;
    logic [3:0]   w_remaining_next;
    logic         r_expired;
    logic         w_expired_next;
    logic         r_zero_pend;
    logic         w_zero_pend_next;
    logic [3:0]   w_n;
    logic         w_tick;

    // Same-cycle reprogram of the selected slot is forwarded to the start.
    assign w_n = (i_reprogram && (i_prog_sel == i_interval)) ? i_prog_value : r_slot[i_interval];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_slot[INT_ARM]    <= T_ARM_DEFAULT;
            r_slot[INT_DRIVER] <= T_DRIVER_DEFAULT;
            r_slot[INT_PASS]   <= T_PASS_DEFAULT;
            r_slot[INT_ALARM]  <= T_ALARM_DEFAULT;
        end else if (i_reprogram) begin
            r_slot[i_prog_sel] <= i_prog_value;
        end
    end

    one_sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_start_timer || (r_state != ST_COUNT)),
        .i_enable  (r_state == ST_COUNT),
        .o_tick    (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 4'd0;
            r_expired   <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_expired   <= w_expired_next;
            r_zero_pend <= w_zero_pend_next;
        end
    end

    // A zero-length start is already committed, so its delayed pulse survives a following start.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_expired_next   = r_zero_pend;
        w_zero_pend_next = 1'b0;
        if (i_start_timer) begin
            w_remaining_next = w_n;
            if (w_n != 4'd0) begin
                w_state_next = ST_COUNT;
            end else begin
                w_state_next     = ST_IDLE;
                w_zero_pend_next = 1'b1;
            end
        end else if ((r_state == ST_COUNT) && w_tick) begin
            w_remaining_next = r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
                w_state_next   = ST_IDLE;
                w_expired_next = 1'b1;
            end
        end
    end

    assign o_expired      = r_expired;
    assign o_busy         = (r_state == ST_COUNT);
    assign o_seconds_left = r_remaining;

endmodule

// File: tb/tb_anti_theft_interval_timer.sv
// tb/tb_anti_theft_interval_timer.sv - bench for anti_theft_interval_timer with timeline reference model
module tb_anti_theft_interval_timer;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] interval;
    logic       start;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic       reprog;
    logic       expired;
    logic       busy;
    logic [3:0] seconds_left;

    int vectors;
    int miscompares;

    anti_theft_interval_timer #(
        .TICK_DIV (TD)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_interval     (interval),
        .i_start_timer  (start),
        .i_prog_sel     (prog_sel),
        .i_prog_value   (prog_value),
        .i_reprogram    (reprog),
        .o_expired      (expired),
        .o_busy         (busy),
        .o_seconds_left (seconds_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a run is a start edge plus a length in seconds; outputs follow from elapsed time.
    int  m_edge;
    int  m_slots [4];
    bit  m_running;
    int  m_start_edge;
    int  m_len;
    int  m_rem;
    int  m_zero_edge;
    bit  m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slots     = '{6, 8, 15, 10};
            m_running   = 0;
            m_rem       = 0;
            m_zero_edge = -1;
            m_exp       = 0;
        end else begin
            int n;
            int el;
            m_edge++;
            m_exp = (m_zero_edge == m_edge);
            if (start) begin
                n = (reprog && prog_sel == interval) ? int'(prog_value) : m_slots[interval];
                m_rem = n;
                if (n > 0) begin
                    m_running    = 1;
                    m_start_edge = m_edge;
                    m_len        = n;
                end else begin
                    m_running   = 0;
                    m_zero_edge = m_edge + 1;
                end
            end else if (m_running) begin
                el    = m_edge - m_start_edge;
                m_rem = m_len - el / TD;
                if (el == m_len * TD) begin
                    m_running = 0;
                    m_exp     = 1;
                end
            end
            if (reprog) m_slots[prog_sel] = int'(prog_value);
        end
    end

    bit chk_en;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_expired", int'(expired), int'(m_exp));
            chk("model_busy", int'(busy), int'(m_running));
            chk("model_seconds_left", int'(seconds_left), m_rem);
        end
    end

    task automatic idle_inputs();
        start = 0; reprog = 0; interval = 0; prog_sel = 0; prog_value = 0;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Applies a start, then returns k such that expired rose at edge t0+k (-1 on timeout).
    task automatic run_start(input logic [1:0] iv, input int bound, output int k);
        interval = iv; start = 1;
        cyc(1);
        start = 0;
        k = -1;
        for (int j = 0; j <= bound; j++) begin
            if (expired) begin
                k = j;
                break;
            end
            cyc(1);
        end
        if (k < 0) chk("expired_timeout", 0, 1);
    endtask

    task automatic write_slot(input logic [1:0] s, input logic [3:0] v);
        reprog = 1; prog_sel = s; prog_value = v;
        cyc(1);
        reprog = 0;
    endtask

    initial begin
        int k;
        int pulses;
        int sl_seen;
        vectors = 0;
        miscompares = 0;
        m_edge = 0;
        chk_en = 0;
        idle_inputs();
        rst_n = 0;
        #1;
        chk("reset_expired", int'(expired), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_seconds_left", int'(seconds_left), 0);
        cyc(2);
        rst_n = 1;
        cyc(1);
        chk_en = 1;

        // Driver slot: 8 s, watch seconds_left step down.
        interval = 2'd1; start = 1;
        cyc(1);
        start = 0;
        chk("s1_busy_k0", int'(busy), 1);
        chk("s1_sl_k0", int'(seconds_left), 8);
        cyc(4);
        chk("s1_sl_k4", int'(seconds_left), 7);
        k = 4;
        while (!expired && k < 100) begin
            cyc(1);
            k++;
        end
        chk("s1_expire_k", k, 32);
        chk("s1_sl_end", int'(seconds_left), 0);
        cyc(1);
        chk("s1_pulse_once", int'(expired), 0);
        cyc(3);

        // Alarm slot reprogrammed to 3 s; arm slot untouched.
        write_slot(2'd3, 4'd3);
        run_start(2'd3, 100, k);
        chk("s2_alarm3_k", k, 12);
        cyc(2);
        run_start(2'd0, 100, k);
        chk("s2_arm_default_k", k, 24);
        cyc(2);

        // Passenger start then restart to arm after 20 cycles.
        interval = 2'd2; start = 1;
        cyc(1);
        start = 0;
        cyc(20);
        pulses = 0;
        run_start(2'd0, 100, k);
        chk("s3_restart_k", k, 24);
        for (int j = 0; j < 60; j++) begin
            cyc(1);
            if (expired) pulses++;
        end
        chk("s3_no_stale_pulse", pulses, 0);

        // Bypass write-through and mid-count reprogram that must not affect the run.
        reprog = 1; prog_sel = 2'd1; prog_value = 4'd2;
        interval = 2'd1; start = 1;
        cyc(1);
        start = 0; reprog = 0;
        cyc(2);
        write_slot(2'd1, 4'd9);
        k = 3;
        while (!expired && k < 100) begin
            cyc(1);
            k++;
        end
        chk("s4_bypass_k", k, 8);
        cyc(2);

        // Zero-length arm slot.
        write_slot(2'd0, 4'd0);
        interval = 2'd0; start = 1;
        cyc(1);
        start = 0;
        chk("s5_zero_busy_k0", int'(busy), 0);
        chk("s5_zero_exp_k0", int'(expired), 0);
        cyc(1);
        chk("s5_zero_exp_k1", int'(expired), 1);
        chk("s5_zero_busy_k1", int'(busy), 0);
        cyc(1);
        chk("s5_zero_exp_k2", int'(expired), 0);

        // Reset mid-count restores defaults.
        interval = 2'd1; start = 1;
        cyc(1);
        start = 0;
        cyc(10);
        #1;
        rst_n = 0;
        #1;
        chk("s6_rst_busy", int'(busy), 0);
        chk("s6_rst_sl", int'(seconds_left), 0);
        chk("s6_rst_exp", int'(expired), 0);
        cyc(2);
        rst_n = 1;
        cyc(1);
        run_start(2'd0, 100, k);
        chk("s6_arm_restored_k", k, 24);
        cyc(1);
        run_start(2'd3, 100, k);
        chk("s6_alarm_restored_k", k, 40);
        run_start(2'd1, 100, k);
        chk("s6_driver_restored_k", k, 32);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 24) == 0);
            interval   = 2'($urandom_range(0, 3));
            reprog     = ($urandom_range(0, 9) == 0);
            prog_sel   = 2'($urandom_range(0, 3));
            prog_value = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 0;
                cyc(1);
                rst_n = 1;
            end
            cyc(1);
        end
        idle_inputs();
        cyc(2);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
